dff_reset_en: RTL and testbench
===============================

// Module: dff_reset_en
//
// PURPOSE
// - Parameterised register bank: a width_p-bit D flip-flop with synchronous
//   active-high reset and a load enable.
// - Used wherever a value must be captured on a valid strobe and held
//   afterwards. Example: latching a full memory-command message on cmd_v so
//   that downstream bus-adapter logic can read address, type and data for the
//   whole transaction.
// - Pure storage: no handshake of its own and no combinational path from
//   input to output.
//
// PARAMETERS
// - width_p      default 1   : register width in bits. Must be >= 1; elaboration error otherwise.
// - reset_val_p  default '0  : value loaded on reset. Truncated or zero-extended to width_p.
//
// PORTS
// - clk_i    in   1        single clock; all state updates on its rising edge
// - reset_i  in   1        synchronous, active-high reset
// - en_i     in   1        load enable; data_i is captured when high
// - data_i   in   width_p  next value
// - data_o   out  width_p  registered value; driven directly from the flops
//
// BEHAVIOUR
// - One clock domain (clk_i). Reset is synchronous and active-high; it is sampled only at posedge clk_i.
// - Priority at each posedge clk_i, highest first:
//   1. reset_i=1            : data_o <= reset_val_p. Applies whatever en_i and data_i are.
//   2. reset_i=0, en_i=1    : data_o <= data_i.
//   3. reset_i=0, en_i=0    : data_o holds its value.
// - Latency: the value captured at edge N is visible on data_o after edge N,
//   and stays stable until the next capturing edge.
// - data_o never changes between clock edges. There is no combinational
//   feed-through from data_i, en_i or reset_i to data_o.
// - Before the first reset edge, data_o is undefined: no initial value, and
//   no reset-free power-up guarantee.
// - Reset mid-operation: asserting reset_i for one cycle discards the held
//   value at that edge. Deasserting reset_i together with en_i=1 loads data_i
//   at the first edge where reset_i=0.
// - en_i held high continuously: the block acts as a plain pipeline register,
//   with data_o(t+1) = data_i(t).
// - All width_p bits are captured together; no per-bit or per-byte enable.
// - Reset value is static (parameter only); there is no run-time reset value.
// - Synthesises to width_p flops with synchronous reset and clock enable (or
//   an equivalent mux). No latches, no gated clock.
//
// TESTING
// - Reset with width_p=8, reset_val_p=8'h00: reset_i=1, en_i=1, data_i=8'hA5
//   for one edge -> data_o=8'h00. Reset overrides enable.
// - Reset value: width_p=8, reset_val_p=8'h3C, reset_i=1 for one edge
//   -> data_o=8'h3C.
// - Load: reset_i=0, en_i=1, data_i=8'h5A at edge N -> data_o=8'h5A after
//   edge N. Then data_i changes with no edge -> data_o unchanged.
// - Hold: after loading 8'h5A, en_i=0 while data_i toggles through 8'hFF and
//   8'h00 for 10 cycles -> data_o stays 8'h5A.
// - Back-to-back streaming: en_i=1 with data_i=1,2,3,4 on consecutive edges
//   -> data_o=1,2,3,4, each one cycle after its input. Then reset_i=1 for one
//   edge mid-stream -> data_o=reset_val_p, and loading resumes on the next edge.
// - Wide instance: width_p=600, load an alternating 01 bit pattern followed
//   by its inverse -> every bit matches, including bits 0 and 599.
//   width_p=1 edge case passes the load, hold and reset scenarios above.

Source files
------------

// File: rtl/dff_reset_en.sv
// Register of width_p bits with a synchronous active-high reset and a load enable.
// data_o is driven only from the flops, so it changes only at clk_i edges.
module dff_reset_en #(
    parameter int                 width_p     = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    generate
        if (width_p < 1) begin : g_bad_width
            $error("dff_reset_en: width_p must be >= 1");
        end
    endgenerate

    // Reset outranks enable; with neither active the flops keep their value.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            data_o <= reset_val_p;
        else if (en_i)
            data_o <= data_i;
    end

endmodule

// File: tb/tb_dff_reset_en.sv
module tb_dff_reset_en;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [7:0]   d8;
  logic [599:0] dw;
  logic         d1;
  logic [7:0]   q8a, q8b;
  logic [599:0] qw;
  logic         q1;
  logic [599:0] pat;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dff_reset_en #(.width_p(8),   .reset_val_p(8'h00)) u8a (.clk_i(clk), .reset_i(rst), .en_i(en), .data_i(d8), .data_o(q8a));
  dff_reset_en #(.width_p(8),   .reset_val_p(8'h3C)) u8b (.clk_i(clk), .reset_i(rst), .en_i(en), .data_i(d8), .data_o(q8b));
  dff_reset_en #(.width_p(600))                      uw  (.clk_i(clk), .reset_i(rst), .en_i(en), .data_i(dw), .data_o(qw));
  dff_reset_en #(.width_p(1),   .reset_val_p(1'b1))  u1  (.clk_i(clk), .reset_i(rst), .en_i(en), .data_i(d1), .data_o(q1));

  task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; d8 = 8'h00; dw = '0; d1 = 1'b0;
    #2;

    rst = 1'b1; en = 1'b1; d8 = 8'hA5; dw = {600{1'b1}}; d1 = 1'b0;
    tick();
    chk("rst_q8a", q8a, 8'h00);
    chk("rst_q8b", q8b, 8'h3C);
    chk("rst_qw",  qw,  600'd0);
    chk("rst_q1",  q1,  1'b1);

    rst = 1'b0; en = 1'b1; d8 = 8'h5A; d1 = 1'b0;
    tick();
    chk("load_q8a", q8a, 8'h5A);
    chk("load_q8b", q8b, 8'h5A);
    chk("load_q1",  q1,  1'b0);

    d8 = 8'hC3; d1 = 1'b1; rst = 1'b1;
    #3;
    chk("noedge_q8a", q8a, 8'h5A);
    chk("noedge_q1",  q1,  1'b0);
    rst = 1'b0;

    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      d8 = (i % 2 == 0) ? 8'hFF : 8'h00;
      d1 = (i % 2 == 0);
      tick();
      chk("hold_q8a", q8a, 8'h5A);
      chk("hold_q8b", q8b, 8'h5A);
      chk("hold_q1",  q1,  1'b0);
    end

    en = 1'b1; d1 = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      d8 = 8'(v);
      tick();
      chk("stream_q8a", q8a, 8'(v));
    end

    rst = 1'b1; d8 = 8'h99;
    tick();
    chk("midrst_q8a", q8a, 8'h00);
    chk("midrst_q8b", q8b, 8'h3C);
    chk("midrst_q1",  q1,  1'b1);
    rst = 1'b0; d8 = 8'h77;
    tick();
    chk("resume_q8a", q8a, 8'h77);
    chk("resume_q8b", q8b, 8'h77);
    chk("resume_q1",  q1,  1'b0);

    d1 = 1'b1;
    tick();
    chk("w1_load", q1, 1'b1);
    en = 1'b0; d1 = 1'b0;
    tick();
    chk("w1_hold", q1, 1'b1);

    pat = {300{2'b01}};
    en = 1'b1; dw = pat;
    tick();
    chk("wide_pat",   qw,      pat);
    chk("wide_b0",    qw[0],   1'b1);
    chk("wide_b599",  qw[599], 1'b0);
    dw = ~pat;
    tick();
    chk("wide_inv",   qw,      ~pat);
    chk("wide_ib0",   qw[0],   1'b0);
    chk("wide_ib599", qw[599], 1'b1);
    en = 1'b0; dw = '0;
    tick();
    chk("wide_hold",  qw,      ~pat);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares != 0)
      $error("FAIL: %0d miscompares", miscompares);
    else
      $display("PASS");
    $finish;
  end

endmodule
